// File: rtl/rr_operand_mux_pkg.sv
// Shared constants and helpers for the operand-select block and its arbiter.
package rr_operand_mux_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Channel-index width; a single channel still needs a 1-bit index port.
  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational fixed-priority / round-robin grant over NUM_CH requests.
// Owns the rotating pointer, which moves past the winner whenever a grant is taken.
module rr_arbiter
  import rr_operand_mux_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ARB_MODE = ARB_RR,
  localparam int CH_W    = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);

  logic [CH_W-1:0] ptr_q;
  logic [CH_W-1:0] ptr_d;
  logic            found;
  int              base_idx;
  int              scan_idx;

  // Search upward from the base index with wrap; base is 0 in fixed mode.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    base_idx  = (ARB_MODE == ARB_RR) ? int'(ptr_q) : 0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan_idx = base_idx + k;
      if (scan_idx >= NUM_CH) begin
        scan_idx = scan_idx - NUM_CH;
      end
      if (!found && req[scan_idx]) begin
        found     = 1'b1;
        grant_idx = CH_W'(scan_idx);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_grant
    assign grant[gi] = found && (grant_idx == CH_W'(gi));
  end

  always_comb begin
    ptr_d = ptr_q;
    if (ARB_MODE != ARB_RR) begin
      ptr_d = '0;
    end else if (advance) begin
      ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + CH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rr_operand_mux.sv
// NUM_CH-way operand select feeding one registered output stage with valid/ready.
// A new beat may load in the same edge the current one drains, so there are no bubbles.
module rr_operand_mux
  import rr_operand_mux_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NUM_CH   = 4,
  parameter int ARB_MODE = ARB_RR,
  localparam int CH_W    = ch_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic              load_en;
  logic              xfer;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic [WIDTH-1:0]  sel_data;

  rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .advance   (xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign load_en  = !out_valid_q || out_ready;
  assign in_ready = (load_en && !rst) ? grant : '0;
  assign xfer     = |in_ready;

  // AND-OR select: an ungranted channel can never leak into the output.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_ch_d    = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_operand_mux.sv
// Directed and random checks of rr_operand_mux in round-robin and fixed-priority builds
// against a cycle-level reference model of the arbitration and output stage.
module tb_rr_operand_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] rr_data, fp_data;
  logic [3:0]  rr_valid, fp_valid, rr_iready, fp_iready;
  logic [15:0] rr_odata, fp_odata;
  logic [1:0]  rr_och, fp_och;
  logic        rr_ovalid, fp_ovalid, rr_oready, fp_oready;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state, index 0 = fixed-priority build, 1 = round-robin build.
  int          m_ptr[2];
  logic        m_ov[2];
  logic [15:0] m_od[2];
  int          m_oc[2];

  always #5 clk = ~clk;

  rr_operand_mux #(.WIDTH(16), .NUM_CH(4), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .in_data(rr_data), .in_valid(rr_valid), .in_ready(rr_iready),
    .out_data(rr_odata), .out_ch(rr_och), .out_valid(rr_ovalid), .out_ready(rr_oready)
  );

  rr_operand_mux #(.WIDTH(16), .NUM_CH(4), .ARB_MODE(0)) u_fp (
    .clk(clk), .rst(rst), .in_data(fp_data), .in_valid(fp_valid), .in_ready(fp_iready),
    .out_data(fp_odata), .out_ch(fp_och), .out_valid(fp_ovalid), .out_ready(fp_oready)
  );

  function automatic int pick(int m, logic [3:0] v);
    int start;
    start = (m == 1) ? m_ptr[m] : 0;
    for (int k = 0; k < 4; k++) begin
      if (v[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(int m, logic [3:0] v, logic ordy);
    int g;
    g = pick(m, v);
    if (rst || !(!m_ov[m] || ordy) || g < 0) return 4'b0000;
    return 4'b0001 << g;
  endfunction

  // Advance one clock and step the model from the inputs seen before the edge.
  task automatic tick();
    logic [3:0]  v[2];
    logic [63:0] d[2];
    logic        o[2];
    int          n_ptr[2], n_oc[2], g;
    logic        n_ov[2];
    logic [15:0] n_od[2];
    v[0] = fp_valid; d[0] = fp_data; o[0] = fp_oready;
    v[1] = rr_valid; d[1] = rr_data; o[1] = rr_oready;
    for (int m = 0; m < 2; m++) begin
      n_ptr[m] = m_ptr[m]; n_ov[m] = m_ov[m]; n_od[m] = m_od[m]; n_oc[m] = m_oc[m];
      if (rst) begin
        n_ptr[m] = 0; n_ov[m] = 1'b0; n_od[m] = 16'h0; n_oc[m] = 0;
      end else begin
        g = pick(m, v[m]);
        if ((!m_ov[m] || o[m]) && g >= 0) begin
          n_ov[m] = 1'b1;
          n_od[m] = d[m][g*16 +: 16];
          n_oc[m] = g;
          n_ptr[m] = (m == 1) ? (g + 1) % 4 : 0;
          $display("[TB] %s xfer ch%0d data %h", (m == 1) ? "rr" : "fp", g, n_od[m]);
        end else if (o[m]) begin
          n_ov[m] = 1'b0;
        end
      end
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      m_ptr[m] = n_ptr[m]; m_ov[m] = n_ov[m]; m_od[m] = n_od[m]; m_oc[m] = n_oc[m];
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rr_valid = 4'b1111; fp_valid = 4'b1111; rr_oready = 1'b1; fp_oready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rr_data[i*16 +: 16] = 16'hA000 + 16'(i);
      fp_data[i*16 +: 16] = 16'hB000 + 16'(i);
    end
    for (int c = 0; c < 2; c++) begin
      #1;
      n_tests++;
      if (rr_iready !== 4'b0000 || fp_iready !== 4'b0000) begin
        n_fail++; $display("FAIL reset_in_ready: got %b/%b expected 0000", rr_iready, fp_iready);
      end
      tick();
    end
    n_tests++;
    if (rr_ovalid !== 1'b0 || rr_odata !== 16'h0 || rr_och !== 2'd0) begin
      n_fail++; $display("FAIL reset_rr_out: got v=%b d=%h ch=%0d expected 0/0000/0", rr_ovalid, rr_odata, rr_och);
    end
    n_tests++;
    if (fp_ovalid !== 1'b0 || fp_odata !== 16'h0 || fp_och !== 2'd0) begin
      n_fail++; $display("FAIL reset_fp_out: got v=%b d=%h ch=%0d expected 0/0000/0", fp_ovalid, fp_odata, fp_och);
    end
    rst = 1'b0;
    fp_valid = 4'b0000;
    #1;
    n_tests++;
    if (rr_iready !== 4'b0001) begin
      n_fail++; $display("FAIL first_grant: got %b expected 0001", rr_iready);
    end
    tick();
    n_tests++;
    if (rr_ovalid !== 1'b1 || rr_odata !== 16'hA000 || rr_och !== 2'd0) begin
      n_fail++; $display("FAIL first_beat: got v=%b d=%h ch=%0d expected 1/a000/0", rr_ovalid, rr_odata, rr_och);
    end
  endtask

  task automatic test_rr_fairness();
    rst = 1'b1; tick(); rst = 1'b0;
    rr_valid = 4'b1111; rr_oready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_tests++;
      if (rr_ovalid !== 1'b1 || rr_och !== 2'(c % 4) || rr_odata !== 16'hA000 + 16'(c % 4)) begin
        n_fail++; $display("FAIL rr_fair[%0d]: got v=%b ch=%0d d=%h expected 1/%0d/%h",
                           c, rr_ovalid, rr_och, rr_odata, c % 4, 16'hA000 + 16'(c % 4));
      end
    end
    rr_valid = 4'b0000;
  endtask

  task automatic test_fixed_priority();
    fp_oready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      fp_valid = (c < 3) ? 4'b1110 : 4'b1000;
      for (int i = 0; i < 4; i++) fp_data[i*16 +: 16] = 16'($urandom);
      #1;
      n_tests++;
      if (fp_iready !== ((c < 3) ? 4'b0010 : 4'b1000)) begin
        n_fail++; $display("FAIL fp_ready[%0d]: got %b expected %b", c, fp_iready, (c < 3) ? 4'b0010 : 4'b1000);
      end
      tick();
      n_tests++;
      if (fp_och !== ((c < 3) ? 2'd1 : 2'd3) || fp_odata !== m_od[0] || fp_ovalid !== 1'b1) begin
        n_fail++; $display("FAIL fp_out[%0d]: got ch=%0d d=%h v=%b expected %0d/%h/1",
                           c, fp_och, fp_odata, fp_ovalid, (c < 3) ? 1 : 3, m_od[0]);
      end
    end
    fp_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    rst = 1'b1; tick(); rst = 1'b0;
    rr_valid = 4'b0100; rr_data[32 +: 16] = 16'h1234; rr_oready = 1'b1;
    tick();
    rr_data[32 +: 16] = 16'h5678; rr_oready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_tests++;
      if (rr_iready !== 4'b0000) begin
        n_fail++; $display("FAIL stall_ready[%0d]: got %b expected 0000", c, rr_iready);
      end
      tick();
      n_tests++;
      if (rr_odata !== 16'h1234 || rr_ovalid !== 1'b1 || rr_och !== 2'd2) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got d=%h v=%b ch=%0d expected 1234/1/2", c, rr_odata, rr_ovalid, rr_och);
      end
    end
    rr_oready = 1'b1;
    #1;
    n_tests++;
    if (rr_iready !== 4'b0100) begin
      n_fail++; $display("FAIL unstall_ready: got %b expected 0100", rr_iready);
    end
    tick();
    n_tests++;
    if (rr_odata !== 16'h5678 || rr_ovalid !== 1'b1) begin
      n_fail++; $display("FAIL no_bubble: got d=%h v=%b expected 5678/1", rr_odata, rr_ovalid);
    end
  endtask

  task automatic test_sparse_wrap();
    // Pointer sits at 3 after the ch2 beats above.
    rr_valid = 4'b0001; rr_data[0 +: 16] = 16'hC0C0;
    #1;
    n_tests++;
    if (rr_iready !== 4'b0001) begin
      n_fail++; $display("FAIL wrap_grant: got %b expected 0001", rr_iready);
    end
    tick();
    // Pointer now 1: with ch0 and ch3 requesting, ch3 wins.
    rr_valid = 4'b1001;
    #1;
    n_tests++;
    if (rr_iready !== 4'b1000) begin
      n_fail++; $display("FAIL ptr_after_wrap: got %b expected 1000", rr_iready);
    end
    tick();
    rr_valid = 4'b0000;
    for (int c = 0; c < 3; c++) tick();
    n_tests++;
    if (rr_ovalid !== 1'b0 || rr_och !== 2'd3) begin
      n_fail++; $display("FAIL drain_idle: got v=%b ch=%0d expected 0/3", rr_ovalid, rr_och);
    end
    // Pointer must still be 0 after idle cycles: ch0 beats ch1.
    rr_valid = 4'b0011;
    #1;
    n_tests++;
    if (rr_iready !== 4'b0001) begin
      n_fail++; $display("FAIL ptr_hold_idle: got %b expected 0001", rr_iready);
    end
    rr_valid = 4'b0000;
  endtask

  task automatic test_mid_reset();
    rr_valid = 4'b0100; rr_oready = 1'b1;
    tick();
    rr_valid = 4'b0000; rr_oready = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n_tests++;
    if (rr_ovalid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_valid: got %b expected 0", rr_ovalid);
    end
    rr_valid = 4'b1111;
    #1;
    n_tests++;
    if (rr_iready !== 4'b0001) begin
      n_fail++; $display("FAIL midrst_grant: got %b expected 0001", rr_iready);
    end
    tick();
    rr_valid = 4'b0000; rr_oready = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 200; c++) begin
      rst       = ($urandom_range(0, 49) == 0);
      rr_valid  = 4'($urandom); fp_valid  = 4'($urandom);
      rr_data   = {$urandom, $urandom}; fp_data = {$urandom, $urandom};
      rr_oready = ($urandom_range(0, 3) != 0); fp_oready = ($urandom_range(0, 3) != 0);
      #1;
      n_tests++;
      if (rr_iready !== exp_ready(1, rr_valid, rr_oready)) begin
        n_fail++; $display("FAIL rnd_rr_ready[%0d]: got %b expected %b", c, rr_iready, exp_ready(1, rr_valid, rr_oready));
      end
      n_tests++;
      if (fp_iready !== exp_ready(0, fp_valid, fp_oready)) begin
        n_fail++; $display("FAIL rnd_fp_ready[%0d]: got %b expected %b", c, fp_iready, exp_ready(0, fp_valid, fp_oready));
      end
      tick();
      n_tests++;
      if (rr_ovalid !== m_ov[1] || rr_odata !== m_od[1] || rr_och !== 2'(m_oc[1])) begin
        n_fail++; $display("FAIL rnd_rr_out[%0d]: got v=%b d=%h ch=%0d expected %b/%h/%0d",
                           c, rr_ovalid, rr_odata, rr_och, m_ov[1], m_od[1], m_oc[1]);
      end
      n_tests++;
      if (fp_ovalid !== m_ov[0] || fp_odata !== m_od[0] || fp_och !== 2'(m_oc[0])) begin
        n_fail++; $display("FAIL rnd_fp_out[%0d]: got v=%b d=%h ch=%0d expected %b/%h/%0d",
                           c, fp_ovalid, fp_odata, fp_och, m_ov[0], m_od[0], m_oc[0]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_ptr[m] = 0; m_ov[m] = 1'b0; m_od[m] = 16'h0; m_oc[m] = 0;
    end
    rst = 1'b1;
    rr_valid = '0; fp_valid = '0; rr_data = '0; fp_data = '0;
    rr_oready = 1'b1; fp_oready = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_rr_fairness();
    test_fixed_priority();
    test_backpressure();
    test_sparse_wrap();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
